io_pwm_led: RTL

IO_PWM_LED -- requirements
Module: io_pwm_led

---
 rtl/io_pwm_led_pkg.sv | 16 +
 rtl/io_pwm_led_if.sv | 21 ++
 rtl/io_pwm_led_chan.sv | 68 ++++++
 rtl/io_pwm_led.sv | 74 +++++++
 4 files changed

// File: rtl/io_pwm_led_pkg.sv
// Shared register map and byte-lane helper for the PWM LED block.
// No ports: constants and functions only.
package io_pkg;

    localparam int REG_PRESCALE = 0;
    localparam int REG_CH0      = 1;
    localparam int EN_BIT       = 16;
    localparam int BLINK_BIT    = 17;
    localparam int PRE_W        = 16;

    // Expand the 4 byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

endpackage

// File: rtl/io_pwm_led_if.sv
// IO store bus: byte-lane write enables, word address, write data.
// master drives the store, slave (the peripheral) receives it.
interface io_pwm_led_if;

    logic [3:0]  st_we_io;
    logic [11:2] st_adr_io;
    logic [31:0] st_data_io;

    modport master (
        output st_we_io,
        output st_adr_io,
        output st_data_io
    );

    modport slave (
        input st_we_io,
        input st_adr_io,
        input st_data_io
    );

endinterface

// File: rtl/io_pwm_led_chan.sv
// One PWM channel: DUTY/EN/BLINK register, period shadow, compare.
// Ports: clk, rst_n, wr_i/we_i/data_i store, wrap_i, pwm_cnt_i, blink_msb_i, pwm_o.
module io_pwm_chan
    import io_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_i,
    input  logic [3:0]       we_i,
    input  logic [31:0]      data_i,
    input  logic             wrap_i,
    input  logic [PWM_W-1:0] pwm_cnt_i,
    input  logic             blink_msb_i,
    output logic             pwm_o
);

    logic [PWM_W-1:0] duty_q, duty_d;
    logic             en_q, en_d;
    logic             blink_q, blink_d;
    logic [PWM_W-1:0] sh_duty_q, sh_duty_d;
    logic             sh_en_q, sh_en_d;
    logic             sh_blink_q, sh_blink_d;
    logic             pwm_d;
    logic [31:0]      m;
    logic             unused_data;

    assign unused_data = ^data_i;
    assign m = wr_i ? lane_mask(we_i) : 32'h0;

    always_comb begin
        duty_d  = (duty_q & ~m[PWM_W-1:0]) | (data_i[PWM_W-1:0] & m[PWM_W-1:0]);
        en_d    = m[EN_BIT] ? data_i[EN_BIT] : en_q;
        blink_d = m[BLINK_BIT] ? data_i[BLINK_BIT] : blink_q;
        // Shadow takes the next-state value so a write on the wrap cycle lands.
        sh_duty_d  = sh_duty_q;
        sh_en_d    = sh_en_q;
        sh_blink_d = sh_blink_q;
        if (wrap_i) begin
            sh_duty_d  = duty_d;
            sh_en_d    = en_d;
            sh_blink_d = blink_d;
        end
        pwm_d = sh_en_q & (pwm_cnt_i < sh_duty_q) & (~sh_blink_q | blink_msb_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q     <= '0;
            en_q       <= 1'b0;
            blink_q    <= 1'b0;
            sh_duty_q  <= '0;
            sh_en_q    <= 1'b0;
            sh_blink_q <= 1'b0;
            pwm_o      <= 1'b0;
        end else begin
            duty_q     <= duty_d;
            en_q       <= en_d;
            blink_q    <= blink_d;
            sh_duty_q  <= sh_duty_d;
            sh_en_q    <= sh_en_d;
            sh_blink_q <= sh_blink_d;
            pwm_o      <= pwm_d;
        end
    end

endmodule

// File: rtl/io_pwm_led.sv
// Multi-channel PWM LED driver: prescaler, PWM and blink counters.
// Ports: clk, rst_n, st (io store bus slave), pwm_out[NCH-1:0].
module io_pwm_led
    import io_pkg::*;
#(
    parameter int         NCH      = 3,
    parameter int         PWM_W    = 8,
    parameter int         BLINK_W  = 6,
    parameter logic [9:0] BASE_ADR = 10'h100
) (
    input  logic           clk,
    input  logic           rst_n,
    io_pwm_led_if.slave    st,
    output logic [NCH-1:0] pwm_out
);

    logic [PRE_W-1:0]   prescale_q, prescale_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [10:0]        off;
    logic               hit;
    logic               tick;
    logic               wrap;
    logic [31:0]        pm;

    // Addresses below the base wrap to >= 1024, so one compare bounds both ends.
    assign off = {1'b0, st.st_adr_io} - {1'b0, BASE_ADR};
    assign hit = (|st.st_we_io) && (off <= 11'(NCH));

    assign pm = (hit && off == 11'(REG_PRESCALE)) ? lane_mask(st.st_we_io) : 32'h0;

    // >= so that lowering PRESCALE below pre_cnt ticks at once instead of wrapping.
    assign tick = (pre_cnt_q >= prescale_q);
    assign wrap = tick & (&pwm_cnt_q);

    always_comb begin
        prescale_d  = (prescale_q & ~pm[PRE_W-1:0]) | (st.st_data_io[PRE_W-1:0] & pm[PRE_W-1:0]);
        pre_cnt_d   = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
        blink_cnt_d = wrap ? blink_cnt_q + 1'b1 : blink_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q  <= '0;
            pre_cnt_q   <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
        end else begin
            prescale_q  <= prescale_d;
            pre_cnt_q   <= pre_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        io_pwm_chan #(
            .PWM_W(PWM_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_i       (hit && off == 11'(REG_CH0 + i)),
            .we_i       (st.st_we_io),
            .data_i     (st.st_data_io),
            .wrap_i     (wrap),
            .pwm_cnt_i  (pwm_cnt_q),
            .blink_msb_i(blink_cnt_q[BLINK_W-1]),
            .pwm_o      (pwm_out[i])
        );
    end

endmodule
